// File: rtl/tpm_pkg.sv
// Shared definitions for the triple-ported memory and its per-port initiators.
package tpm_pkg;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int NUM_PORTS = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
  } tpm_req_t;
endpackage

// File: rtl/tpm_sync_fifo.sv
// Single-clock FIFO with registered storage; head word is visible one cycle after its push.
module tpm_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  // A pop frees the slot the same cycle, so a full FIFO may push and pop together.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));
endmodule

// File: rtl/tpm_port_initiator.sv
// Client-side initiator for one memory port: issues requests, tracks them by tag, returns read data in order.
module tpm_port_initiator #(
  parameter int ADDR_W          = tpm_pkg::ADDR_W,
  parameter int DATA_W          = tpm_pkg::DATA_W,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [ADDR_W-1:0]                    cmd_addr,
  input  logic [DATA_W-1:0]                    cmd_wdata,
  input  logic                                 cmd_wen,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [DATA_W-1:0]                    rsp_data,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W-1:0]                    mem_data_in,
  output logic                                 mem_wen,
  output logic                                 mem_valid_in,
  input  logic                                 mem_freeze,
  input  logic [DATA_W-1:0]                    mem_data_out,
  input  logic                                 mem_valid_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_unexpected_rsp
);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int RW = $clog2(RSP_DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
  } req_t;

  req_t          req_q;
  logic          slot_free, accept, rsp_hit, rd_rsp, rsp_pop;
  logic          tag_empty, tag_full, tag_head, rsp_empty, rsp_full;
  logic [OW-1:0] reads_pending;
  logic [RW-1:0] rsp_count;
  logic [31:0]   read_credit_used;

  assign slot_free = ~mem_valid_in | ~mem_freeze;

  // Every accepted read owns a response slot until the client pops it.
  assign read_credit_used = 32'(reads_pending) + 32'(rsp_count);
  assign cmd_ready = slot_free & ~tag_full & (cmd_wen | (read_credit_used < 32'(RSP_DEPTH)));
  assign accept    = cmd_valid & cmd_ready;

  // Tag holds cmd_wen: 0 marks a read whose data must be kept.
  assign rsp_hit = mem_valid_out & ~tag_empty;
  assign rd_rsp  = rsp_hit & ~tag_head;
  assign rsp_pop = rsp_valid & rsp_ready;

  assign mem_addr     = req_q.addr;
  assign mem_data_in  = req_q.data;
  assign mem_wen      = req_q.wen;
  assign rsp_valid    = ~rsp_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q        <= '0;
      mem_valid_in <= 1'b0;
    end else if (slot_free) begin
      mem_valid_in <= accept;
      if (accept) req_q <= '{addr: cmd_addr, data: cmd_wdata, wen: cmd_wen};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reads_pending      <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      reads_pending <= reads_pending + OW'(accept & ~cmd_wen) - OW'(rd_rsp);
      if (mem_valid_out && tag_empty) err_unexpected_rsp <= 1'b1;
    end
  end

  tpm_sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .wdata   (cmd_wen),
    .pop     (rsp_hit),
    .rdata   (tag_head),
    .empty   (tag_empty),
    .full    (tag_full),
    .count   (outstanding)
  );

  tpm_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rd_rsp),
    .wdata   (mem_data_out),
    .pop     (rsp_pop),
    .rdata   (rsp_data),
    .empty   (rsp_empty),
    .full    (rsp_full),
    .count   (rsp_count)
  );

  a_rsp_credit: assert property (@(posedge clk) disable iff (!reset_n) rd_rsp |-> (!rsp_full || rsp_pop));
endmodule

// File: tb/tb_tpm_port_initiator.sv
// Bench for tpm_port_initiator: table vectors, directed corner sequences and a random run against a queue model.
module tb_tpm_port_initiator;
  localparam int AW = 12, DW = 16, MAXO = 4, RD = 4;

  logic          clk = 1'b0, reset_n;
  logic          cmd_valid, cmd_ready, cmd_wen, rsp_valid, rsp_ready;
  logic [AW-1:0] cmd_addr, mem_addr;
  logic [DW-1:0] cmd_wdata, rsp_data, mem_data_in, mem_data_out;
  logic          mem_wen, mem_valid_in, mem_freeze, mem_valid_out, err;
  logic [2:0]    outstanding;

  tpm_port_initiator dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wen(cmd_wen),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wen(mem_wen),
    .mem_valid_in(mem_valid_in), .mem_freeze(mem_freeze),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
    .outstanding(outstanding), .err_unexpected_rsp(err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0, err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: in-order, per-request latency, optional response throttling.
  typedef struct { int due; logic [DW-1:0] data; } mrsp_t;
  mrsp_t         rq[$];
  logic [DW-1:0] tb_mem [0:4095];
  int cyc = 0, issue_cnt = 0, resp_used = 0, resp_budget = -1;
  int inject_req = 0, inject_ack = 0, lat = 2;

  initial begin
    mrsp_t r;
    mem_valid_out = 1'b0;
    mem_data_out  = '0;
    for (int i = 0; i < 4096; i++) tb_mem[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n && mem_valid_in && !mem_freeze) begin
        issue_cnt++;
        if (mem_wen) begin
          tb_mem[mem_addr] = mem_data_in;
          rq.push_back(mrsp_t'{cyc + lat - 1, DW'($urandom)});
        end else rq.push_back(mrsp_t'{cyc + lat - 1, tb_mem[mem_addr]});
      end
      #1;
      mem_valid_out = 1'b0;
      mem_data_out  = DW'($urandom);
      if (inject_req != inject_ack) begin
        inject_ack    = inject_req;
        mem_valid_out = 1'b1;
      end else if (rq.size() > 0 && rq[0].due <= cyc && (resp_budget < 0 || resp_used < resp_budget)) begin
        r = rq.pop_front();
        mem_valid_out = 1'b1;
        mem_data_out  = r.data;
        resp_used++;
      end
    end
  end

  // Reference model: accepted commands in order, read data predicted at accept time.
  logic [DW-1:0] ref_mem [0:4095];
  bit            ref_tags[$];
  logic [DW-1:0] exp_q[$];
  int            ref_avail = 0;
  bit            ref_busy = 0, ref_err = 0;

  initial begin
    bit ready_e;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        ref_tags.delete(); exp_q.delete();
        ref_avail = 0; ref_busy = 0; ref_err = 0;
      end else begin
        ready_e = (!ref_busy || !mem_freeze) && ref_tags.size() < MAXO && (cmd_wen || exp_q.size() < RD);
        chk("cmd_ready", cmd_ready, ready_e);
        chk("mem_valid_in", mem_valid_in, ref_busy);
        chk("outstanding", outstanding, ref_tags.size());
        chk("rsp_valid", rsp_valid, ref_avail > 0);
        chk("err_unexpected_rsp", err, ref_err);
        if (ref_avail > 0 && rsp_ready) begin
          chk("rsp_data", rsp_data, exp_q.pop_front());
          ref_avail--;
        end
        if (mem_valid_out) begin
          if (ref_tags.size() == 0) ref_err = 1;
          else if (ref_tags.pop_front() == 1'b0) ref_avail++;
        end
        if (cmd_valid && ready_e) begin
          ref_tags.push_back(cmd_wen);
          if (cmd_wen) ref_mem[cmd_addr] = cmd_wdata;
          else exp_q.push_back(ref_mem[cmd_addr]);
          ref_busy = 1;
        end else if (!mem_freeze) ref_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_wen = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !ok; i++) begin @(posedge clk); ok = cmd_ready; end
    #2; cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d, output bit ok);
    ok = 0; d = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1; d = rsp_data; end
    end
    #2;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (ref_tags.size() == 0 && ref_avail == 0 && rq.size() == 0) done = 1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_valid_in"}, mem_valid_in, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_data_in"}, mem_data_in, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  typedef struct { logic wen; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp; } vec_t;
  vec_t tv[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    bit ok;
    int ic;
    tv[0] = '{1'b1, 12'h0A5, 16'h1234, 16'h0000};
    tv[1] = '{1'b0, 12'h0A5, 16'h0000, 16'h1234};
    tv[2] = '{1'b1, 12'hFFF, 16'hBEEF, 16'h0000};
    tv[3] = '{1'b0, 12'hFFF, 16'h0000, 16'hBEEF};
    tv[4] = '{1'b0, 12'h000, 16'h0000, 16'h0000};
    tv[5] = '{1'b1, 12'h0A5, 16'h5A5A, 16'h0000};
    tv[6] = '{1'b0, 12'h0A5, 16'h0000, 16'h5A5A};
    tv[7] = '{1'b1, 12'h000, 16'hFFFF, 16'h0000};
    tv[8] = '{1'b0, 12'h000, 16'h0000, 16'hFFFF};
    tv[9] = '{1'b0, 12'hFFF, 16'h0000, 16'hBEEF};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_wen = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; mem_freeze = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset("rst");
    reset_n = 1'b1;
    tick();

    // Table: one memory issue per command, read data in order, write acks dropped.
    for (int i = 0; i < 10; i++) begin
      ic = issue_cnt;
      send_cmd(tv[i].wen, tv[i].addr, tv[i].wdata);
      if (!tv[i].wen) begin
        wait_rsp(d, ok);
        if (!ok) chk("tbl_rsp_timeout", 0, 1);
        else chk("tbl_rsp_data", d, tv[i].exp);
      end else repeat (4) tick();
      chk("tbl_issue_count", issue_cnt - ic, 1);
      chk("tbl_outstanding", outstanding, 0);
    end

    // Freeze holds the request stable and blocks new commands.
    send_cmd(1'b0, 12'h0A5, '0);
    mem_freeze = 1'b1;
    ic = issue_cnt;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_valid", mem_valid_in, 1);
      chk("frz_addr", mem_addr, 12'h0A5);
      chk("frz_ready", cmd_ready, 0);
      chk("frz_no_issue", issue_cnt, ic);
    end
    mem_freeze = 1'b0;
    tick();
    chk("frz_issue", issue_cnt, ic + 1);
    chk("frz_valid_drop", mem_valid_in, 0);
    drain();

    // Outstanding limit.
    resp_budget = resp_used;
    for (int k = 0; k < 4; k++) send_cmd(1'b0, AW'(12'h100 + k), '0);
    tick(); tick();
    chk("cr_outstanding", outstanding, 4);
    cmd_wen = 1'b0; #1; chk("cr_read_blocked", cmd_ready, 0);
    cmd_wen = 1'b1; #1; chk("cr_write_blocked", cmd_ready, 0);
    resp_budget = resp_used + 1;
    for (int i = 0; i < 20 && resp_used != resp_budget; i++) tick();
    tick();
    chk("cr_outstanding_after", outstanding, 3);
    cmd_wen = 1'b1; #1; chk("cr_ready_again", cmd_ready, 1);
    resp_budget = -1;
    drain();

    // Response FIFO full: reads refused, writes accepted.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_cmd(1'b0, AW'(12'h0A5 + k), '0);
    for (int i = 0; i < 50 && ref_avail != 4; i++) tick();
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_outstanding", outstanding, 0);
    cmd_wen = 1'b0; #1; chk("full_read_refused", cmd_ready, 0);
    cmd_wen = 1'b1; #1; chk("full_write_ok", cmd_ready, 1);
    send_cmd(1'b1, 12'h200, 16'hCAFE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_wen = 1'b0; #1; chk("full_read_reenabled", cmd_ready, 1);
    rsp_ready = 1'b1;
    drain();

    // Accept and response on the same edge.
    for (int w = 1; w >= 0; w--) begin
      send_cmd(1'b1, 12'h300, 16'h1111);
      tick(); tick();
      send_cmd(w[0], 12'h300, 16'h2222);
      chk("same_edge_outstanding", outstanding, 1);
      drain();
    end

    // Response with nothing outstanding.
    inject_req++;
    tick(); tick();
    chk("unexp_err", err, 1);
    repeat (5) tick();
    chk("unexp_err_sticky", err, 1);
    chk("unexp_outstanding", outstanding, 0);

    // Asynchronous reset with reads in flight; their late responses are unexpected.
    resp_budget = resp_used;
    send_cmd(1'b0, 12'h0A5, '0);
    send_cmd(1'b0, 12'h0A6, '0);
    tick(); tick();
    #1; reset_n = 1'b0;
    #1; check_reset("async_rst");
    tick();
    reset_n = 1'b1;
    resp_budget = -1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin tick(); ok = err; end
    chk("late_rsp_err", err, 1);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid  = ($urandom_range(0, 9) < 7);
      cmd_wen    = 1'($urandom_range(0, 1));
      cmd_addr   = AW'($urandom_range(0, 15));
      cmd_wdata  = DW'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      mem_freeze = ($urandom_range(0, 4) == 0);
      lat        = $urandom_range(1, 4);
      tick();
    end
    cmd_valid = 1'b0; mem_freeze = 1'b0; rsp_ready = 1'b1;
    drain();
    chk("end_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
